// File: rtl/iso_xform_ctrl_pkg.sv
// Shared types for the isomorphic-field byte transform: matrix/row types,
// controller state encoding, identity matrix and the GF(2) row dot product.
package iso_xform_ctrl_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ROWS      = 8;
    localparam int unsigned ROW_CNT_W = 3;

    // Bit 0 is the MSB throughout, matching the [0:7] port orientation.
    typedef logic [0:BYTE_W-1] mm_row_t;
    typedef mm_row_t [0:ROWS-1] mm_matrix_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } xform_state_e;

    localparam mm_matrix_t MM_IDENTITY = {
        8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    // One output bit: parity of the row masked by the input byte.
    function automatic logic row_dot(input mm_row_t row, input mm_row_t x);
        return ^(row & x);
    endfunction

endpackage

// File: rtl/iso_xform_ctrl_input_transform.sv
// Combinational 8x8 GF(2) matrix-vector product mapping a byte from the
// standard field into the isomorphic field.
module input_transform
    import iso_xform_ctrl_pkg::*;
(
    input  mm_matrix_t l_matrix,
    input  mm_row_t    in_byte,
    output mm_row_t    xform_c
);

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        assign xform_c[i] = row_dot(l_matrix[i], in_byte);
    end

endmodule

// File: rtl/iso_xform_ctrl.sv
// Controller for the isomorphic-field byte transform: row-by-row loading of
// the L matrix through a shadow copy, and a one-deep registered byte stream.
module iso_xform_ctrl
    import iso_xform_ctrl_pkg::*;
#(
    parameter bit IDENTITY_ON_RESET = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_start,
    input  logic          cfg_valid,
    input  logic [0:7]    cfg_row,
    output logic          cfg_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:7]    in_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:7]    out_byte,
    output logic          busy,
    output logic          l_loaded
);

    localparam xform_state_e RESET_STATE  = IDENTITY_ON_RESET ? ST_RUN : ST_EMPTY;
    localparam mm_matrix_t   RESET_MATRIX = IDENTITY_ON_RESET ? MM_IDENTITY : '0;
    localparam logic         RESET_LOADED = IDENTITY_ON_RESET;
    localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(ROWS - 1);

    xform_state_e         state_q, state_d;
    logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
    mm_matrix_t           shadow_q, shadow_d;
    mm_matrix_t           active_q;
    logic                 l_loaded_q;
    logic                 out_valid_q;
    mm_row_t              out_byte_q;
    mm_row_t              xform_c;

    logic restart_c;
    logic row_we_c;
    logic commit_c;
    logic in_fire_c;
    logic out_fire_c;

    // A restart takes priority over a row beat presented in the same cycle.
    assign restart_c  = cfg_start && (state_q == ST_EMPTY || state_q == ST_LOAD);
    assign row_we_c   = cfg_valid && (state_q == ST_LOAD) && !cfg_start;
    assign commit_c   = row_we_c && (row_cnt_q == LAST_ROW);
    assign in_fire_c  = in_valid && in_ready;
    assign out_fire_c = out_valid_q && out_ready;

    // Next state and state-decoded handshake outputs.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        in_ready  = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (cfg_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (commit_c) state_d = ST_RUN;
            end
            ST_RUN: begin
                in_ready = !out_valid_q || out_ready;
                if (cfg_start) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!out_valid_q) state_d = ST_LOAD;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    // Shadow rows and row counter; the counter wraps to 0 on the commit beat.
    always_comb begin
        shadow_d  = shadow_q;
        row_cnt_d = row_cnt_q;
        if (restart_c) begin
            shadow_d  = '0;
            row_cnt_d = '0;
        end else if (row_we_c) begin
            shadow_d[row_cnt_q] = cfg_row;
            row_cnt_d           = row_cnt_q + ROW_CNT_W'(1);
        end
    end

    // The active matrix only changes on the commit beat and includes that beat's row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q  <= '0;
            shadow_q   <= '0;
            active_q   <= RESET_MATRIX;
            l_loaded_q <= RESET_LOADED;
        end else begin
            row_cnt_q <= row_cnt_d;
            shadow_q  <= shadow_d;
            if (commit_c) begin
                active_q   <= shadow_d;
                l_loaded_q <= 1'b1;
            end
        end
    end

    input_transform u_input_transform (
        .l_matrix (active_q),
        .in_byte  (in_byte),
        .xform_c  (xform_c)
    );

    // One-deep output register; a new accept wins over a simultaneous drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
        end else if (in_fire_c) begin
            out_valid_q <= 1'b1;
            out_byte_q  <= xform_c;
        end else if (out_fire_c) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign l_loaded  = l_loaded_q;

endmodule

// File: tb/tb_iso_xform_ctrl.sv
// Directed and randomized bench for iso_xform_ctrl against a queue-based
// reference model of the matrix load and byte stream.
module tb_iso_xform_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_start, cfg_valid, cfg_ready;
    logic [7:0] cfg_row;
    logic       in_valid, in_ready;
    logic [7:0] in_byte;
    logic       out_valid, out_ready;
    logic [7:0] out_byte;
    logic       busy, l_loaded;

    logic       id_cfg_ready, id_in_ready, id_out_valid, id_busy, id_l_loaded;
    logic [7:0] id_out_byte;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_active [8];
    logic [7:0] m_shadow [8];
    int         beat_cnt;
    bit         m_loaded;
    logic [7:0] exp_q [$];

    iso_xform_ctrl #(.IDENTITY_ON_RESET(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_row(cfg_row), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .busy(busy), .l_loaded(l_loaded)
    );

    iso_xform_ctrl #(.IDENTITY_ON_RESET(1'b1)) dut_id (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_row(cfg_row), .cfg_ready(id_cfg_ready),
        .in_valid(in_valid), .in_ready(id_in_ready), .in_byte(in_byte),
        .out_valid(id_out_valid), .out_ready(out_ready), .out_byte(id_out_byte),
        .busy(id_busy), .l_loaded(id_l_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Output bit i (bit 0 = MSB) is the parity of popcount(row i AND x).
    function automatic logic [7:0] model_xf(input logic [7:0] x);
        int r = 0;
        for (int i = 0; i < 8; i++)
            r = r + (($countones(m_active[i] & x) % 2) << (7 - i));
        return 8'(r);
    endfunction

    // One clock: drive at negedge, observe 1ns later, update model for the coming posedge.
    task automatic cyc(input logic iv, input logic [7:0] ib, input logic ordy,
                       input logic cs, input logic cv, input logic [7:0] cr);
        @(negedge clk);
        in_valid = iv; in_byte = ib; out_ready = ordy;
        cfg_start = cs; cfg_valid = cv; cfg_row = cr;
        #1;
        chk("out_valid", out_valid, (exp_q.size() != 0) ? 8'd1 : 8'd0);
        if (out_valid && exp_q.size() != 0) chk("out_byte", out_byte, exp_q[0]);
        chk("l_loaded", l_loaded, m_loaded ? 8'd1 : 8'd0);
        if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) exp_q.push_back(model_xf(in_byte));
        if (cs) begin
            beat_cnt = 0;
        end else if (cv && cfg_ready) begin
            m_shadow[beat_cnt] = cr;
            beat_cnt++;
            if (beat_cnt == 8) begin
                m_active = m_shadow;
                m_loaded = 1'b1;
                beat_cnt = 0;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 8'h00, ordy, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_load();
        int k = 0;
        do begin
            idle(1'b1);
            k++;
        end while (!cfg_ready && k < 10);
        chk("wait_load", cfg_ready, 8'd1);
    endtask

    task automatic load(input logic [7:0] rows [8]);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        wait_load();
        for (int r = 0; r < 8; r++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, rows[r]);
            chk("beat_busy", busy, 8'd1);
        end
        idle(1'b1);
        chk("run_cfg_ready", cfg_ready, 8'd0);
        chk("run_busy", busy, 8'd0);
        chk("run_in_ready", in_ready, 8'd1);
    endtask

    task automatic flush();
        int k = 0;
        while (exp_q.size() != 0 && k < 8) begin
            idle(1'b1);
            k++;
        end
        idle(1'b1);
        chk("flush_empty", (exp_q.size() == 0) ? 8'd1 : 8'd0, 8'd1);
    endtask

    task automatic rand_stream(input int n);
        logic       pend = 1'b0;
        logic [7:0] src  = 8'($urandom);
        for (int c = 0; c < n; c++) begin
            if (!pend) pend = 1'($urandom_range(0, 1));
            cyc(pend, src, 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, 8'h00);
            if (in_valid && in_ready) begin
                pend = 1'b0;
                src  = 8'($urandom);
            end
        end
        flush();
    endtask

    logic [7:0] ident [8];
    logic [7:0] all_ff [8];
    logic [7:0] rnd [8];

    initial begin
        ident  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        all_ff = '{default: 8'hFF};
        foreach (m_active[i]) begin m_active[i] = 8'h00; m_shadow[i] = 8'h00; end
        beat_cnt = 0; m_loaded = 1'b0;
        rst_n = 1'b0;
        cfg_start = 0; cfg_valid = 0; cfg_row = 0;
        in_valid = 0; in_byte = 0; out_ready = 0;

        // Reset values of both parameterisations
        #23;
        chk("rst_out_valid", out_valid, 8'd0);
        chk("rst_out_byte", out_byte, 8'h00);
        chk("rst_l_loaded", l_loaded, 8'd0);
        chk("rst_busy", busy, 8'd0);
        chk("rst_cfg_ready", cfg_ready, 8'd0);
        chk("rst_in_ready", in_ready, 8'd0);
        chk("idrst_l_loaded", id_l_loaded, 8'd1);
        chk("idrst_in_ready", id_in_ready, 8'd1);
        chk("idrst_busy", id_busy, 8'd0);
        chk("idrst_out_valid", id_out_valid, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // EMPTY refuses input; identity-reset instance transforms straight away
        cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("empty_in_ready", in_ready, 8'd0);
        chk("empty_busy", busy, 8'd0);
        idle(1'b1);
        chk("id_inst_valid", id_out_valid, 8'd1);
        chk("id_inst_byte", id_out_byte, 8'hA5);

        // Identity load and 00,53,FF stream
        load(ident);
        cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'h53, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("id_00", out_byte, 8'h00);
        cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("id_53", out_byte, 8'h53);
        idle(1'b1);
        chk("id_ff", out_byte, 8'hFF);
        flush();

        // All-FF rows: even parity inputs map to 00, odd to FF
        load(all_ff);
        cyc(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("ff_03", out_byte, 8'h00);
        idle(1'b1);
        chk("ff_01", out_byte, 8'hFF);
        flush();

        // Backpressure: one byte held, no further accepts, then in-order release
        load(ident);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00);
            chk("stall_in_ready", in_ready, 8'd0);
            chk("stall_byte", out_byte, 8'h11);
        end
        cyc(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("rel_22", out_byte, 8'h22);
        flush();

        // cfg_start with a simultaneous accept, then DRAIN held by backpressure
        cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'h44, 1'b0, (k == 1), 1'b0, 8'h00);
            chk("drain_busy", busy, 8'd1);
            chk("drain_in_ready", in_ready, 8'd0);
            chk("drain_cfg_ready", cfg_ready, 8'd0);
            chk("drain_byte", out_byte, 8'h3C);
        end
        idle(1'b1);
        wait_load();
        chk("load_busy", busy, 8'd1);
        foreach (rnd[r]) rnd[r] = 8'($urandom);
        load(rnd);
        rand_stream(20);

        // Interrupted load: only the second full set of rows is committed
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        wait_load();
        for (int r = 0; r < 3; r++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'($urandom));
        foreach (rnd[r]) rnd[r] = 8'($urandom);
        load(rnd);
        rand_stream(30);

        // Randomized matrices and traffic
        for (int it = 0; it < 3; it++) begin
            foreach (rnd[r]) rnd[r] = 8'($urandom);
            load(rnd);
            rand_stream(150);
        end

        // Asynchronous reset mid-load after five rows
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        wait_load();
        for (int r = 0; r < 5; r++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'($urandom));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cfg_ready", cfg_ready, 8'd0);
        chk("arst_busy", busy, 8'd0);
        chk("arst_out_valid", out_valid, 8'd0);
        chk("arst_l_loaded", l_loaded, 8'd0);
        chk("arst_out_byte", out_byte, 8'h00);
        m_loaded = 1'b0;
        beat_cnt = 0;
        exp_q.delete();
        foreach (m_active[i]) m_active[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h77);
        chk("post_rst_cfg_ready", cfg_ready, 8'd0);
        chk("post_rst_in_ready", in_ready, 8'd0);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
